// File: rtl/load_store_unit.sv
// Load/store unit: turns a core load/store request into one memory bus transfer,
// handling lane steering, load extension, alignment/funct3 errors and bus timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  access_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {3'b000, 3'b001, 3'b010};
    else    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  // Only meaningful for legal funct3: bits [1:0] give the access size.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return d;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    addr_d   = addr_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          if (!f3_legal(req_we, req_funct3)) begin
            err_d   = 2'b10;
            rdata_d = '0;
            state_d = DONE;
          end else if (misaligned(req_funct3, req_addr[1:0])) begin
            err_d   = 2'b01;
            rdata_d = '0;
            state_d = DONE;
          end else begin
            we_d     = req_we;
            funct3_d = req_funct3;
            off_d    = req_addr[1:0];
            addr_d   = {req_addr[31:2], 2'b00};
            wstrb_d  = req_we ? store_strb(req_funct3, req_addr[1:0]) : 4'b0000;
            wdata_d  = req_we ? store_data(req_funct3, req_wdata) : 32'd0;
            state_d  = BUS;
          end
        end
      end
      BUS: begin
        if (bus_ready) begin
          rdata_d = we_q ? 32'd0 : load_extract(funct3_q, off_q, bus_rdata);
          err_d   = 2'b00;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 2'b11;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      addr_q   <= addr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus_valid  = (state_q == BUS);
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_wdata  = wdata_q;
  assign rsp_valid  = (state_q == DONE);
  assign rsp_rdata  = rdata_q;
  assign access_err = err_q;
  assign stall      = req_valid & ~rsp_valid;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of accesses with a response scoreboard,
// plus hand sequences for held requests, idle bus_ready and mid-transfer reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  access_err;
  logic        bus_valid, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .access_err(access_err),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          drop;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic [1:0]  e_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    bit          chk_rdata;
  } exp_t;

  exp_t exp_q[$];
  vec_t vt[18];
  vec_t sw_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every completion must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got err=%0d rdata=%h expected no response", access_err, rsp_rdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_err", {30'd0, access_err}, {30'd0, e.err});
        if (e.chk_rdata) chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
  task automatic run_vec(input vec_t v);
    int lat, nbus, exp_lat, exp_bus;
    bit done;
    exp_t e;
    if (v.e_err == 2'b00)      begin exp_lat = v.waits + 2; exp_bus = v.waits + 1; end
    else if (v.e_err == 2'b11) begin exp_lat = 256;         exp_bus = 255;         end
    else                       begin exp_lat = 1;           exp_bus = 0;           end
    e.rdata = v.e_rdata;
    e.err = v.e_err;
    e.chk_rdata = (v.e_err == 2'b00 || v.e_err == 2'b11);
    exp_q.push_back(e);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    bus_rdata = v.rdata; bus_ready = 1'b0;
    lat = 0; nbus = 0; done = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      chk("stall", {31'd0, stall}, {31'd0, (req_valid && lat != exp_lat)});
      if (bus_valid) begin
        chk("bus_addr", bus_addr, v.e_addr);
        chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, v.e_wstrb});
        chk("bus_wdata", bus_wdata, v.e_wdata);
        chk("bus_we", {31'd0, bus_we}, {31'd0, v.we});
        nbus++;
        if (v.drop && nbus == 1) req_valid = 1'b0;
        bus_ready = (nbus - 1 == v.waits);
      end else begin
        bus_ready = 1'b0;
      end
      if (rsp_valid) begin
        done = 1;
        chk("latency", lat, exp_lat);
        chk("bus_cycles", nbus, exp_bus);
        req_valid = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: got no rsp_valid within %0d cycles expected rsp at cycle %0d", lat, exp_lat);
    end
    bus_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    //         we    f3      addr          wdata         rdata         waits   drop  e_addr        e_wstrb  e_wdata       e_rdata       e_err
    vt[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0,      0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80, 2'b00};
    vt[1]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0,      0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080, 2'b00};
    vt[2]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_0000, 1,      0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_80FF, 2'b00};
    vt[3]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_8765, 0,      0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_8765, 2'b00};
    vt[4]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h1234_8765, 0,      0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF87, 2'b00};
    vt[5]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 2,      0, 32'h0000_0104, 4'b0000, 32'h0,        32'hDEAD_BEEF, 2'b00};
    vt[6]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'hFFFF_FFFF, 3,      0, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0,        2'b00};
    vt[7]  = '{1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'hFFFF_FFFF, 0,      0, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0,        2'b00};
    vt[8]  = '{1'b1, 3'b000, 32'h0000_0303, 32'h1234_56A5, 32'hFFFF_FFFF, 1,      0, 32'h0000_0300, 4'b1000, 32'hA5A5_A5A5, 32'h0,        2'b00};
    vt[9]  = '{1'b1, 3'b001, 32'h0000_0300, 32'hCAFE_1234, 32'hFFFF_FFFF, 0,      0, 32'h0000_0300, 4'b0011, 32'h1234_1234, 32'h0,        2'b00};
    vt[10] = '{1'b1, 3'b010, 32'h0000_0040, 32'h1122_3344, 32'hFFFF_FFFF, 0,      0, 32'h0000_0040, 4'b1111, 32'h1122_3344, 32'h0,        2'b00};
    vt[11] = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,         0,      0, 32'h0,         4'b0000, 32'h0,        32'h0,        2'b01};
    vt[12] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,         0,      0, 32'h0,         4'b0000, 32'h0,        32'h0,        2'b01};
    vt[13] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,         0,      0, 32'h0,         4'b0000, 32'h0,        32'h0,        2'b10};
    vt[14] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,         0,      0, 32'h0,         4'b0000, 32'h0,        32'h0,        2'b10};
    vt[15] = '{1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h00FF_0000, 0,      0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_00FF, 2'b00};
    vt[16] = '{1'b0, 3'b101, 32'h0000_0010, 32'h0,        32'hAAAA_5555, 100000, 0, 32'h0000_0010, 4'b0000, 32'h0,        32'h0,        2'b11};
    vt[17] = '{1'b0, 3'b010, 32'h0000_0008, 32'h0,        32'h55AA_55AA, 1,      1, 32'h0000_0008, 4'b0000, 32'h0,        32'h55AA_55AA, 2'b00};
    sw_vec = vt[10];

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    #2;
    chk("reset_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_access_err", {30'd0, access_err}, 32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(vt[i]);

    // bus_ready with no transfer in flight must do nothing; rsp_rdata keeps the last load.
    bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_bus_valid", {31'd0, bus_valid}, 32'd0);
      chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rdata_hold", rsp_rdata, 32'h55AA_55AA);
    end
    bus_ready = 1'b0;

    // A request still held during DONE is only taken again once back in IDLE.
    exp_q.push_back('{32'h0, 2'b01, 1'b0});
    exp_q.push_back('{32'h0, 2'b01, 1'b0});
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h6;
    @(negedge clk); chk("held_rsp_c1", {31'd0, rsp_valid}, 32'd1);
    chk("held_stall_c1", {31'd0, stall}, 32'd0);
    @(negedge clk); chk("held_rsp_c2", {31'd0, rsp_valid}, 32'd0);
    chk("held_stall_c2", {31'd0, stall}, 32'd1);
    @(negedge clk); chk("held_rsp_c3", {31'd0, rsp_valid}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk); chk("held_rsp_c4", {31'd0, rsp_valid}, 32'd0);

    // Reset in the second bus cycle aborts the transfer at once.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104;
    bus_ready = 1'b0; bus_rdata = 32'h1234_5678;
    @(negedge clk); chk("pre_reset_bus_c1", {31'd0, bus_valid}, 32'd1);
    @(negedge clk); chk("pre_reset_bus_c2", {31'd0, bus_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("arst_bus_addr", bus_addr, 32'd0);
    chk("arst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("arst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("arst_bus_wdata", bus_wdata, 32'd0);
    chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_rsp_rdata", rsp_rdata, 32'd0);
    chk("arst_access_err", {30'd0, access_err}, 32'd0);
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    reset = 1'b0;
    run_vec(sw_vec);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum BUS-state cycles without bus_ready before the access aborts.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: core requests a load or store; held stable while stall=1.
REQ-005 SHALL have port req_we, input, 1 bit: 1=store, 0=load.
REQ-006 SHALL have port req_funct3, input, 3 bits: access size/sign, using RISC-V load/store funct3 encoding.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address (ALU result).
REQ-008 SHALL have port req_wdata, input, 32 bits: store data (rs2), right-aligned.
REQ-009 SHALL have port stall, output, 1 bit: core must hold the PC and request.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata, output, 32 bits: aligned, extended load result.
REQ-012 SHALL have port access_err, output, 2 bits: error code, valid with rsp_valid.
  - 00: none
  - 01: misaligned
  - 10: illegal funct3
  - 11: timeout
REQ-013 SHALL have ports bus_valid (output, 1), bus_we (output, 1), bus_addr (output, 32), bus_wstrb (output, 4), bus_wdata (output, 32): memory bus request.
REQ-014 SHALL have ports bus_ready (input, 1) and bus_rdata (input, 32): transfer completes in the cycle bus_valid & bus_ready; bus_rdata is sampled in that cycle.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUS and DONE.
REQ-016 IDLE SHALL behave as follows:
  - req_valid with a legal, aligned request: latch the request, go to BUS next cycle.
  - Illegal or misaligned request: go directly to DONE with the error code and no bus transaction.
REQ-017 Legal funct3 values SHALL be:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All other values: access_err=10.
REQ-018 Misalignment SHALL be detected as: halfword with addr[0]=1, or word with addr[1:0]!=00; result is access_err=01.
REQ-019 In BUS, bus_valid SHALL be 1 and bus_we/bus_addr/bus_wstrb/bus_wdata SHALL stay constant until bus_ready.
REQ-020 bus_addr SHALL be {addr[31:2],2'b00}.
REQ-021 Store lanes SHALL be:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{byte}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: wstrb = 1111, wdata = wdata.
REQ-022 Loads SHALL drive bus_wstrb=0000 and bus_wdata=0.
REQ-023 Load extraction SHALL select the byte or halfword indexed by addr[1:0] from bus_rdata; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-024 rsp_rdata SHALL be registered at the bus_ready cycle and hold until the next completion; stores complete with rsp_rdata=0.
REQ-025 BUS SHALL keep a cycle counter cleared on entry; if TIMEOUT_CYCLES cycles elapse without bus_ready, bus_valid drops and the FSM goes to DONE with access_err=11 and rsp_rdata=0.
REQ-026 DONE SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; a request present in DONE SHALL NOT be accepted until IDLE.
REQ-027 stall SHALL equal req_valid & ~rsp_valid (combinational).
REQ-028 Minimum latency SHALL be: request in cycle 0, bus_valid in cycle 1, with bus_ready in cycle 1 rsp_valid in cycle 2.
REQ-029 Deassertion of req_valid during BUS SHALL NOT abort the transfer; the transfer completes and rsp_valid still pulses.
REQ-030 bus_ready while bus_valid=0 SHALL be ignored.

Reset
REQ-031 Asserting reset SHALL immediately force the following, including mid-transfer:
  - FSM=IDLE, timeout counter=0.
  - bus_valid=0, bus_we=0, bus_addr=0, bus_wstrb=0, bus_wdata=0.
  - rsp_valid=0, rsp_rdata=0, access_err=00.
REQ-032 After reset deassertion the first request SHALL be accepted in the first IDLE cycle.

Verification
REQ-033 LB addr=0x103, bus_rdata=0x80FF_0000, zero wait -> bus_addr=0x100, rsp_rdata=0x0000_0080 sign-extended i.e. 0xFFFF_FF80 (byte3=0x80), rsp_valid in cycle 2.
REQ-034 SH addr=0x202, wdata=0x0000_BEEF, bus_ready after 3 cycles -> bus_wstrb=1100, bus_wdata=0xBEEF_BEEF held stable 4 cycles, stall high until the rsp_valid cycle.
REQ-035 LW addr=0x006 -> no bus_valid, rsp_valid in cycle 1, access_err=01; funct3=011 -> access_err=10.
REQ-036 LHU addr=0x10, bus_ready never -> bus_valid high for 255 cycles, then rsp_valid with access_err=11 and rsp_rdata=0.
REQ-037 Reset asserted in BUS cycle 2 -> bus_valid=0 immediately, no rsp_valid; a following SW to 0x40 completes normally with wstrb=1111.
